// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared FSM states and constants for the sequential binary-to-BCD converter
package bin_to_bcd_seq_pkg;
  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int unsigned MAX_VALUE = 9999;
  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// add3_nibble: combinational BCD corrector, adds 3 when the nibble is 5 or more
//   i_nib  in  4  scratch nibble
//   o_nib  out 4  corrected nibble (max 12, never carries)
module add3_nibble
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= ADJ_THRESHOLD) ? i_nib + ADJ_ADD : i_nib;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with 9999 saturation
//   i_clk    in   1       system clock
//   i_rst    in   1       synchronous active-high reset
//   i_start  in   1       conversion request, sampled only in IDLE
//   i_din    in   DATA_W  unsigned value captured with an accepted start
//   o_busy   out  1       conversion in progress
//   o_done   out  1       one-cycle pulse when new digits are valid
//   o_ovf    out  1       last captured value exceeded 9999
//   o_uni/o_dec/o_cen/o_mil out 4 each  BCD digits, held between conversions
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [3:0]        o_uni,
  output logic [3:0]        o_dec,
  output logic [3:0]        o_cen,
  output logic [3:0]        o_mil
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t            r_state, w_state_n;
  logic [DATA_W-1:0] r_bin, w_bin_n;
  logic [BCD_W-1:0]  r_bcd, w_bcd_n, w_adj;
  logic [BCD_W-1:0]  r_dig, w_dig_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic              r_ovf_lat, w_ovf_lat_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic              r_ovf, w_ovf_n;
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    add3_nibble u_add3 (.i_nib(r_bcd[4*g +: 4]), .o_nib(w_adj[4*g +: 4]));
  end
  always_comb begin
    w_state_n   = r_state;
    w_bin_n     = r_bin;
    w_bcd_n     = r_bcd;
    w_dig_n     = r_dig;
    w_cnt_n     = r_cnt;
    w_ovf_lat_n = r_ovf_lat;
    w_busy_n    = r_busy;
    w_ovf_n     = r_ovf;
    w_done_n    = 1'b0;
    case (r_state)
      IDLE: if (i_start) begin
        w_bin_n     = i_din;
        w_bcd_n     = '0;
        w_cnt_n     = '0;
        w_ovf_lat_n = 32'(i_din) > MAX_VALUE;
        w_busy_n    = 1'b1;
        w_state_n   = ADJ;
      end
      ADJ: begin
        w_bcd_n   = w_adj;
        w_state_n = SHIFT;
      end
      SHIFT: begin
        w_bcd_n   = {r_bcd[BCD_W-2:0], r_bin[DATA_W-1]};
        w_bin_n   = r_bin << 1;
        w_cnt_n   = r_cnt + CW'(1);
        w_state_n = (w_cnt_n == CW'(DATA_W)) ? DONE : ADJ;
      end
      DONE: begin
        // Scratch may hold a wrapped 5th digit for values above 9999; saturate instead
        w_dig_n   = r_ovf_lat ? {BCD_DIGITS{4'd9}} : r_bcd;
        w_ovf_n   = r_ovf_lat;
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_dig     <= '0;
      r_cnt     <= '0;
      r_ovf_lat <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_bin     <= w_bin_n;
      r_bcd     <= w_bcd_n;
      r_dig     <= w_dig_n;
      r_cnt     <= w_cnt_n;
      r_ovf_lat <= w_ovf_lat_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_ovf     <= w_ovf_n;
    end
  end
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_mil  = r_dig[15:12];
  assign o_cen  = r_dig[11:8];
  assign o_dec  = r_dig[7:4];
  assign o_uni  = r_dig[3:0];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] din = '0;
  logic        busy, done, ovf;
  logic [3:0]  uni, dec, cen, mil;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_exp = 16'h0000;
  bin_to_bcd_seq #(.DATA_W(14)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din),
    .o_busy(busy), .o_done(done), .o_ovf(ovf),
    .o_uni(uni), .o_dec(dec), .o_cen(cen), .o_mil(mil)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [13:0] v, input logic [15:0] exp, input logic exp_ovf,
                     input int rs_at, input logic [13:0] rs_v);
    int n;
    int busy_cnt;
    int dones;
    @(negedge clk);
    start = 1'b1;
    din = v;
    @(negedge clk);
    start = 1'b0;
    din = 14'h3fff;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (n == 5) chk("hold_digits", {mil, cen, dec, uni}, last_exp);
      start = (n == rs_at);
      if (n == rs_at) din = rs_v;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, 29);
    chk("busy_cycles", busy_cnt, 29);
    chk("busy_at_done", busy, 0);
    chk("digits", {mil, cen, dec, uni}, exp);
    chk("ovf", ovf, exp_ovf);
    last_exp = exp;
    @(negedge clk);
    chk("done_width", done, 0);
    dones = 0;
    repeat (32) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("extra_done", dones, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    int dones;
    int last;
    repeat (2) @(negedge clk);
    chk("rst_digits", {mil, cen, dec, uni}, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    run(14'd1234, 16'h1234, 1'b0, -1, 14'd0);
    run(14'd0, 16'h0000, 1'b0, -1, 14'd0);
    run(14'd9999, 16'h9999, 1'b0, -1, 14'd0);
    run(14'd10000, 16'h9999, 1'b1, -1, 14'd0);
    run(14'd16383, 16'h9999, 1'b1, -1, 14'd0);
    run(14'd7, 16'h0007, 1'b0, -1, 14'd0);
    run(14'd4321, 16'h4321, 1'b0, 9, 14'd5555);
    run(14'd1234, 16'h1234, 1'b0, -1, 14'd0);
    @(negedge clk);
    start = 1'b1;
    din = 14'd8765;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_digits", {mil, cen, dec, uni}, 16'h0000);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    dones = 0;
    repeat (35) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_quiet", dones, 0);
    start = 1'b1;
    rst = 1'b1;
    din = 14'd99;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    chk("rst_wins_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_wins_idle", busy, 0);
    last_exp = 16'h0000;
    run(14'd58, 16'h0058, 1'b0, -1, 14'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    din = 14'd42;
    @(negedge clk);
    dones = 0;
    last = -1;
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        if (last < 0) chk("held_first", n, 29);
        else chk("held_gap", n - last, 30);
        last = n;
        dones++;
      end
      if (n >= 29) chk("held_digits", {mil, cen, dec, uni}, 16'h0042);
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_count", dones, 3);
    chk("held_ovf", ovf, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
